// File: rtl/char_stream_pkg.sv
// Shared definitions for the character input/output streams: command codes,
// special characters, state encodings and word-size helpers.
package char_stream_pkg;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'd0,
        CMD_START     = 2'd1,
        CMD_XFER_BYTE = 2'd2,
        CMD_FLUSH     = 2'd3
    } cmd_e;

    // The byte-transfer code is GET_NEXT_BYTE on the input side, PUT_BYTE here.
    localparam cmd_e CMD_GET_NEXT_BYTE = CMD_XFER_BYTE;
    localparam cmd_e CMD_PUT_BYTE      = CMD_XFER_BYTE;

    localparam logic [7:0] NO_CHAR          = 8'hFF;
    localparam logic [7:0] DEFAULT_PAD_CHAR = 8'h00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_GUARD,
        W_WAIT
    } wstate_e;

    // AMCI size code for a word of the given byte count.
    function automatic int unsigned size_code(input int unsigned bytes);
        return $clog2(bytes);
    endfunction

    // Width of a byte-lane index, never zero.
    function automatic int unsigned cnt_width(input int unsigned bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/amci_write_slot.sv
// One-word pending slot feeding the AMCI write engine; accepts a word when the
// slot is empty and tracks sticky write-response errors.
module amci_write_slot
    import char_stream_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [AXI_DATA_WIDTH-1:0] in_word,
    input  logic [AXI_ADDR_WIDTH-1:0] in_addr,
    output logic                      in_accept,
    input  logic                      err_clr,
    output logic                      busy,
    output logic                      error,
    output logic [AXI_ADDR_WIDTH-1:0] AMCI_WADDR,
    output logic [AXI_DATA_WIDTH-1:0] AMCI_WDATA,
    output logic                      AMCI_WRITE,
    input  logic [1:0]                AMCI_WRESP,
    input  logic                      AMCI_WIDLE
);

    wstate_e                   wstate, wstate_nx;
    logic                      pend_valid;
    logic [AXI_DATA_WIDTH-1:0] pend_word;
    logic [AXI_ADDR_WIDTH-1:0] pend_addr;
    logic                      wr_done;

    assign in_accept  = ~pend_valid;
    assign busy       = pend_valid | (wstate != W_IDLE);
    assign AMCI_WADDR = pend_addr;
    assign AMCI_WDATA = pend_word;

    always_comb begin
        wstate_nx  = wstate;
        AMCI_WRITE = 1'b0;
        wr_done    = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (pend_valid && AMCI_WIDLE) begin
                    AMCI_WRITE = 1'b1;
                    wstate_nx  = W_GUARD;
                end
            end
            // Engine may not have dropped WIDLE yet; skip one cycle.
            W_GUARD: wstate_nx = W_WAIT;
            W_WAIT: begin
                if (AMCI_WIDLE) begin
                    wr_done   = 1'b1;
                    wstate_nx = W_IDLE;
                end
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate     <= W_IDLE;
            pend_valid <= 1'b0;
            pend_word  <= '0;
            pend_addr  <= '0;
            error      <= 1'b0;
        end else begin
            wstate <= wstate_nx;
            if (in_valid && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_word  <= in_word;
                pend_addr  <= in_addr;
            end else if (wr_done) begin
                pend_valid <= 1'b0;
            end
            if (err_clr)
                error <= 1'b0;
            else if (wr_done && (AMCI_WRESP != 2'b00))
                error <= 1'b1;
        end
    end

endmodule

// File: rtl/char_ostream.sv
// Byte-to-word packing output stream: assembles PUT_BYTE characters into
// RAM words and hands completed words to the AMCI write slot.
module char_ostream
    import char_stream_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [7:0]  PAD_CHAR       = DEFAULT_PAD_CHAR
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [1:0]                CMD,
    input  logic [AXI_ADDR_WIDTH-1:0] ADDR,
    input  logic [7:0]                DATA_IN,
    output logic                      READY,
    output logic                      IDLE,
    output logic                      ERROR,
    output logic [AXI_ADDR_WIDTH-1:0] AMCI_WADDR,
    output logic [2:0]                AMCI_WSIZE,
    output logic [AXI_DATA_WIDTH-1:0] AMCI_WDATA,
    output logic                      AMCI_WRITE,
    input  logic [1:0]                AMCI_WRESP,
    input  logic                      AMCI_WIDLE
);

    localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W = cnt_width(BYTES);

    logic [AXI_DATA_WIDTH-1:0] asm_word, filled;
    logic [CNT_W-1:0]          asm_cnt;
    logic                      asm_full;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;

    logic put_ok, flush_ok, start_ok, complete;
    logic slot_accept, slot_busy;

    assign READY      = resetn & ~asm_full;
    assign IDLE       = ~asm_full & ~slot_busy;
    assign AMCI_WSIZE = 3'(size_code(BYTES));

    always_comb begin
        put_ok   = READY && (CMD == CMD_PUT_BYTE);
        flush_ok = READY && (CMD == CMD_FLUSH) && (asm_cnt != '0);
        start_ok = IDLE && (CMD == CMD_START);
        complete = (put_ok && (asm_cnt == CNT_W'(BYTES - 1))) || flush_ok;
        filled   = asm_word;
        for (int unsigned k = 0; k < BYTES; k++) begin
            if (put_ok && (k == 32'(asm_cnt)))
                filled[8*k +: 8] = DATA_IN;
            if (flush_ok && (k >= 32'(asm_cnt)))
                filled[8*k +: 8] = PAD_CHAR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            asm_word <= '0;
            asm_cnt  <= '0;
            asm_full <= 1'b0;
            wr_addr  <= '0;
        end else if (start_ok) begin
            wr_addr  <= ADDR;
            asm_cnt  <= '0;
            asm_full <= 1'b0;
        end else if (asm_full) begin
            // Parked word moves into the slot as soon as it drains.
            if (slot_accept) begin
                asm_full <= 1'b0;
                asm_cnt  <= '0;
                wr_addr  <= wr_addr + AXI_ADDR_WIDTH'(BYTES);
            end
        end else if (complete) begin
            asm_word <= filled;
            if (slot_accept) begin
                asm_cnt <= '0;
                wr_addr <= wr_addr + AXI_ADDR_WIDTH'(BYTES);
            end else begin
                asm_full <= 1'b1;
            end
        end else if (put_ok) begin
            asm_word <= filled;
            asm_cnt  <= asm_cnt + CNT_W'(1);
        end
    end

    amci_write_slot #(
        .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
    ) u_slot (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (complete | asm_full),
        .in_word   (asm_full ? asm_word : filled),
        .in_addr   (wr_addr),
        .in_accept (slot_accept),
        .err_clr   (start_ok),
        .busy      (slot_busy),
        .error     (ERROR),
        .AMCI_WADDR(AMCI_WADDR),
        .AMCI_WDATA(AMCI_WDATA),
        .AMCI_WRITE(AMCI_WRITE),
        .AMCI_WRESP(AMCI_WRESP),
        .AMCI_WIDLE(AMCI_WIDLE)
    );

endmodule
